// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// trace entry layout and the byte-lane merge used by stores.
package dm_responder_pkg;

  // Clear-in-progress versus normal operation
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int WORD_W  = 32;
  localparam int TRACE_W = 96;

  // One committed store as seen by the trace consumer
  typedef struct packed {
    logic [31:0] pc;    // [95:64]
    logic [31:0] addr;  // [63:32], word aligned
    logic [31:0] data;  // [31:0], word after the merge
  } trace_entry_t;

  // Replace the enabled byte lanes of old_word with those of new_word
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [3:0]        byteen
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Bus bundle between the core data port / trace consumer and the
// responder. The master side is the core plus the trace consumer.
interface dm_responder_if;
  import dm_responder_pkg::*;

  // Core data port
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;

  // Store trace stream
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    output m_inst_addr,
    input  m_data_rdata,
    input  trace_valid,
    output trace_ready,
    input  trace_pc,
    input  trace_addr,
    input  trace_data
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    input  m_inst_addr,
    output m_data_rdata,
    output trace_valid,
    input  trace_ready,
    output trace_pc,
    output trace_addr,
    output trace_data
  );

endinterface

// File: rtl/dm_responder_trace_fifo.sv
// Synchronous FIFO for store trace entries. Pop is a valid/ready
// handshake; a push into a full FIFO is accepted only if the same cycle
// pops, otherwise it is dropped and the sticky overflow flag is raised.
module dm_responder_trace_fifo #(
  parameter int  WIDTH = 96,
  parameter int  DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_entry,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // Pointers carry one extra wrap bit so full and empty are distinct
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fill;
  logic             empty;
  logic             full;
  logic             pop;
  logic             accept;
  logic             drop;

  // Occupancy decode and handshake qualification
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
             (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    pop    = !empty && ready;
    accept = push && (!full || pop);
    drop   = push && full && !pop;
    fill   = wr_ptr - rd_ptr;
  end

  assign valid = !empty;
  assign count = CNT_W'(fill);
  // Head reads zero while empty so stale slots never leak out
  assign head  = empty ? '0 : slots[rd_ptr[IDX_W-1:0]];

  // Pointer and sticky-flag state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (accept) begin
      slots[wr_ptr[IDX_W-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder behind the core's data port. Holds a word RAM
// with byte-enabled stores and a zero-latency read, clears the RAM after
// reset, and traces every committed store into a drainable FIFO.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int  ADDR_WIDTH = 12,
  parameter int  FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  dm_responder_if.slave    bus,
  output logic             init_done,
  output logic [CNT_W-1:0] trace_count,
  output logic             trace_overflow,
  output logic             oob_err
);

  localparam int WORDS = 2 ** ADDR_WIDTH;

  logic [WORD_W-1:0]     mem [WORDS];

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic [ADDR_WIDTH-1:0] init_ptr_next;

  logic                  running;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [WORD_W-1:0]     old_word;
  logic [WORD_W-1:0]     merged;
  logic                  store;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [WORD_W-1:0]     wr_word;

  trace_entry_t          push_entry;
  trace_entry_t          head_entry;

  // Address decode and store merge against the currently committed word
  always_comb begin
    running  = (state == ST_RUN);
    in_range = (bus.m_data_addr[31:ADDR_WIDTH+2] == '0);
    word_idx = bus.m_data_addr[ADDR_WIDTH+1:2];
    old_word = mem[word_idx];
    merged   = byte_merge(old_word, bus.m_data_wdata, bus.m_data_byteen);
    store    = running && in_range && (bus.m_data_byteen != 4'b0000);
  end

  // Read returns the pre-edge word; zero during the clear or out of range
  assign bus.m_data_rdata = (running && in_range) ? old_word : '0;

  assign init_done = running;

  // FSM state register; a reset mid-clear restarts from word 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_next;
      init_ptr <= init_ptr_next;
    end
  end

  // Next state: sweep every word once, then stay in RUN
  always_comb begin
    state_next    = state;
    init_ptr_next = init_ptr;
    case (state)
      ST_INIT: begin
        init_ptr_next = init_ptr + ADDR_WIDTH'(1);
        if (init_ptr == '1) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // RAM write port shared between the clear sweep and core stores
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_word = merged;
    if (!running) begin
      wr_en   = 1'b1;
      wr_idx  = init_ptr;
      wr_word = '0;
    end else if (store) begin
      wr_en = 1'b1;
    end
  end

  // Word RAM, not reset: the clear sweep establishes its contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_word;
    end
  end

  // Sticky out-of-range flag; any RUN cycle with a bad address counts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_err <= 1'b0;
    end else if (running && !in_range) begin
      oob_err <= 1'b1;
    end
  end

  // Trace entry for the store committing this cycle
  always_comb begin
    push_entry.pc   = bus.m_inst_addr;
    push_entry.addr = {bus.m_data_addr[31:2], 2'b00};
    push_entry.data = merged;
  end

  dm_responder_trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (store),
    .push_entry (push_entry),
    .valid      (bus.trace_valid),
    .ready      (bus.trace_ready),
    .head       (head_entry),
    .count      (trace_count),
    .overflow   (trace_overflow)
  );

  assign bus.trace_pc   = head_entry.pc;
  assign bus.trace_addr = head_entry.addr;
  assign bus.trace_data = head_entry.data;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed stores and reads; expected trace
// entries go into a queue that a negedge monitor consumes on each pop.
module tb_dm_responder;
  import dm_responder_pkg::*;

  localparam int AW = 4;
  localparam int FD = 8;
  localparam int CW = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic [CW-1:0] trace_count;
  logic          trace_overflow;
  logic          oob_err;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [95:0]   exp_q[$];

  dm_responder_if bus ();

  dm_responder #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .init_done      (init_done),
    .trace_count    (trace_count),
    .trace_overflow (trace_overflow),
    .oob_err        (oob_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Move to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input string name, input logic [31:0] exp);
    bus.m_data_addr = addr;
    #1;
    check(name, bus.m_data_rdata, exp);
  endtask

  // One-cycle store; trace_ready held at rdy for that cycle only
  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic [31:0] pc, input logic rdy);
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = data;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    bus.trace_ready   = rdy;
    cyc();
    bus.m_data_byteen = 4'b0000;
    bus.trace_ready   = 1'b0;
  endtask

  task automatic drain();
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (trace_count == 0) break;
    end
    bus.trace_ready = 1'b0;
    check("drain_count", 32'(trace_count), 0);
    check("drain_valid", 32'(bus.trace_valid), 0);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 15) check({tag, "_done_at15"}, 32'(init_done), 0);
    end
    check({tag, "_done_at16"}, 32'(init_done), 1);
  endtask

  // Trace monitor: every pop must match the oldest expected entry
  always @(negedge clk) begin
    logic [95:0] exp_e;
    if (reset && bus.trace_valid && bus.trace_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL trace_pop: got pc=%h addr=%h data=%h, expected no entry",
                 bus.trace_pc, bus.trace_addr, bus.trace_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bus.trace_pc, bus.trace_addr, bus.trace_data} !== exp_e) begin
          n_fail++;
          $display("FAIL trace_pop: got pc=%h addr=%h data=%h, expected pc=%h addr=%h data=%h",
                   bus.trace_pc, bus.trace_addr, bus.trace_data,
                   exp_e[95:64], exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset             = 1'b0;
    bus.m_data_addr   = '0;
    bus.m_data_wdata  = '0;
    bus.m_data_byteen = 4'b0000;
    bus.m_inst_addr   = '0;
    bus.trace_ready   = 1'b0;
    repeat (3) cyc();

    // Reset state
    check("rst_init_done", 32'(init_done), 0);
    check("rst_count", 32'(trace_count), 0);
    check("rst_valid", 32'(bus.trace_valid), 0);
    check("rst_overflow", 32'(trace_overflow), 0);
    check("rst_oob", 32'(oob_err), 0);
    check("rst_trace_pc", bus.trace_pc, 0);

    // Clear sweep: 16 words, a store during INIT is ignored
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 3) rd(32'h8, "init_rdata", 0);
      if (i == 5) begin
        bus.m_data_addr   = 32'h3C;
        bus.m_data_wdata  = 32'hFFFF_FFFF;
        bus.m_data_byteen = 4'hF;
      end
      if (i == 6) bus.m_data_byteen = 4'h0;
      if (i == 15) check("init_done_at15", 32'(init_done), 0);
    end
    check("init_done_at16", 32'(init_done), 1);
    check("init_count", 32'(trace_count), 0);
    for (int w = 0; w < 16; w++) rd(32'(w * 4), $sformatf("clear_word%0d", w), 0);
    check("init_oob", 32'(oob_err), 0);

    // Byte merge
    cyc();
    exp_q.push_back({32'h3000, 32'h8, 32'h1122_3344});
    store(32'h8, 32'h1122_3344, 4'b1111, 32'h3000, 1'b0);
    exp_q.push_back({32'h3004, 32'h8, 32'h1122_AB44});
    store(32'h9, 32'h0000_AB00, 4'b0010, 32'h3004, 1'b0);
    check("merge_count", 32'(trace_count), 2);
    rd(32'h8, "merge_rdata", 32'h1122_AB44);
    drain();

    // Read during write
    cyc();
    bus.m_data_addr   = 32'h4;
    bus.m_data_wdata  = 32'hDEAD_BEEF;
    bus.m_data_byteen = 4'hF;
    bus.m_inst_addr   = 32'h3008;
    #1;
    check("rdw_old", bus.m_data_rdata, 0);
    exp_q.push_back({32'h3008, 32'h4, 32'hDEAD_BEEF});
    cyc();
    bus.m_data_byteen = 4'h0;
    #1;
    check("rdw_new", bus.m_data_rdata, 32'hDEAD_BEEF);
    drain();

    // Full FIFO and overflow
    cyc();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({32'(32'h4000 + 4 * i), 32'(32'h10 + 4 * i), 32'(32'hA0 + i)});
      store(32'(32'h10 + 4 * i), 32'(32'hA0 + i), 4'hF, 32'(32'h4000 + 4 * i), 1'b0);
    end
    check("full_count", 32'(trace_count), 8);
    check("full_overflow", 32'(trace_overflow), 1);
    check("full_valid", 32'(bus.trace_valid), 1);
    check("full_head_pc", bus.trace_pc, 32'h4000);
    check("full_head_data", bus.trace_data, 32'hA0);
    rd(32'h30, "dropped_store_ram", 32'hA8);
    exp_q.push_back({32'h4100, 32'h34, 32'hB0});
    store(32'h34, 32'hB0, 4'hF, 32'h4100, 1'b1);
    check("full_pushpop_count", 32'(trace_count), 8);
    check("full_pushpop_overflow", 32'(trace_overflow), 1);
    drain();

    // Drain with trace_ready pattern 1,0,1,1
    cyc();
    exp_q.push_back({32'h5000, 32'h0, 32'h0BAD_F00D});
    store(32'h0, 32'h0BAD_F00D, 4'hF, 32'h5000, 1'b0);
    exp_q.push_back({32'h5004, 32'h3C, 32'h1234_5678});
    store(32'h3C, 32'h1234_5678, 4'hF, 32'h5004, 1'b0);
    exp_q.push_back({32'h5008, 32'h20, 32'h00C0_00EE});
    store(32'h22, 32'h00C0_FFEE, 4'b0101, 32'h5008, 1'b0);
    check("drain3_count", 32'(trace_count), 3);
    bus.trace_ready = 1'b1;
    cyc();
    bus.trace_ready = 1'b0;
    #1;
    check("stall_head_pc", bus.trace_pc, 32'h5004);
    cyc();
    check("stall_hold_data", bus.trace_data, 32'h1234_5678);
    check("stall_hold_valid", 32'(bus.trace_valid), 1);
    bus.trace_ready = 1'b1;
    cyc();
    cyc();
    bus.trace_ready = 1'b0;
    check("drain3_valid_low", 32'(bus.trace_valid), 0);
    check("drain3_queue_left", 32'(exp_q.size()), 0);

    // Out-of-range store
    cyc();
    bus.m_data_addr   = 32'h40;
    bus.m_data_wdata  = 32'hFFFF_FFFF;
    bus.m_data_byteen = 4'hF;
    bus.m_inst_addr   = 32'h6000;
    #1;
    check("oob_rdata", bus.m_data_rdata, 0);
    cyc();
    bus.m_data_byteen = 4'h0;
    #1;
    check("oob_flag", 32'(oob_err), 1);
    check("oob_count", 32'(trace_count), 0);
    rd(32'h0, "oob_ram_unchanged", 32'h0BAD_F00D);

    // Mid-INIT reset
    store(32'h8, 32'h77, 4'hF, 32'h6004, 1'b0);
    check("pre_reset_count", 32'(trace_count), 1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("areset_init_done", 32'(init_done), 0);
    check("areset_count", 32'(trace_count), 0);
    check("areset_overflow", 32'(trace_overflow), 0);
    check("areset_oob", 32'(oob_err), 0);
    check("areset_valid", 32'(bus.trace_valid), 0);
    check("areset_trace_data", bus.trace_data, 0);
    cyc();
    reset = 1'b1;
    repeat (5) cyc();
    check("midinit_done", 32'(init_done), 0);
    rd(32'h8, "midinit_rdata", 0);
    reset = 1'b0;
    #1;
    check("midinit_reset_done", 32'(init_done), 0);
    cyc();
    reset = 1'b1;
    wait_init("restart");
    rd(32'h0, "restart_word0", 0);
    rd(32'h8, "restart_word2", 0);
    rd(32'h3C, "restart_word15", 0);
    check("restart_count", 32'(trace_count), 0);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
